// File: rtl/axis_frame_arbiter_ctrl.sv
// Frame-granular 4:1 AXI-Stream arbiter with a registered egress beat.
// Optional stall watchdog enabled by defining AXIS_ARB_WDOG_EN.
module axis_frame_arbiter_ctrl #(
  parameter int    DATA_WIDTH   = 8,
  parameter int    USER_WIDTH   = 1,
  parameter string ARB_TYPE     = "PRIORITY",
  parameter string LSB_PRIORITY = "HIGH",
  parameter int    WDOG_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_0_tdata,
  input  logic                  input_0_tvalid,
  input  logic                  input_0_tlast,
  input  logic [USER_WIDTH-1:0] input_0_tuser,
  output logic                  input_0_tready,
  input  logic [DATA_WIDTH-1:0] input_1_tdata,
  input  logic                  input_1_tvalid,
  input  logic                  input_1_tlast,
  input  logic [USER_WIDTH-1:0] input_1_tuser,
  output logic                  input_1_tready,
  input  logic [DATA_WIDTH-1:0] input_2_tdata,
  input  logic                  input_2_tvalid,
  input  logic                  input_2_tlast,
  input  logic [USER_WIDTH-1:0] input_2_tuser,
  output logic                  input_2_tready,
  input  logic [DATA_WIDTH-1:0] input_3_tdata,
  input  logic                  input_3_tvalid,
  input  logic                  input_3_tlast,
  input  logic [USER_WIDTH-1:0] input_3_tuser,
  output logic                  input_3_tready,
  output logic [DATA_WIDTH-1:0] output_tdata,
  output logic                  output_tvalid,
  output logic                  output_tlast,
  output logic [USER_WIDTH-1:0] output_tuser,
  input  logic                  output_tready,
  output logic                  grant_valid,
  output logic [1:0]            grant_idx,
  output logic                  o_dbg_state
);

  localparam bit RR       = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");

  if (WDOG_CYCLES < 2) begin : g_bad_wdog_cycles
    $error("WDOG_CYCLES must be at least 2");
  end

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_grant_idx;
  logic [1:0]            r_ptr;
  logic                  r_out_tvalid;
  logic [DATA_WIDTH-1:0] r_out_tdata;
  logic                  r_out_tlast;
  logic [USER_WIDTH-1:0] r_out_tuser;

  logic [3:0]            w_tvalid;
  logic [3:0]            w_tlast;
  logic [DATA_WIDTH-1:0] w_tdata [4];
  logic [USER_WIDTH-1:0] w_tuser [4];
  logic [1:0]            w_win;
  logic                  w_active;
  logic                  w_out_free;
  logic                  w_sel_tvalid;
  logic                  w_accept;
  logic                  w_wdog_fire;
  logic                  w_synth_load;
  logic                  w_frame_end;
  logic [3:0]            w_ready;

  assign w_tvalid   = {input_3_tvalid, input_2_tvalid, input_1_tvalid, input_0_tvalid};
  assign w_tlast    = {input_3_tlast, input_2_tlast, input_1_tlast, input_0_tlast};
  assign w_tdata[0] = input_0_tdata;
  assign w_tdata[1] = input_1_tdata;
  assign w_tdata[2] = input_2_tdata;
  assign w_tdata[3] = input_3_tdata;
  assign w_tuser[0] = input_0_tuser;
  assign w_tuser[1] = input_1_tuser;
  assign w_tuser[2] = input_2_tuser;
  assign w_tuser[3] = input_3_tuser;

  // Fixed priority is a circular search from a constant origin; round robin starts at r_ptr.
  always_comb begin
    logic [1:0] v_base;
    logic [1:0] v_cand;
    logic       v_found;
    w_win   = 2'd0;
    v_found = 1'b0;
    v_cand  = 2'd0;
    v_base  = RR ? r_ptr : (LSB_HIGH ? 2'd0 : 2'd3);
    for (int i = 0; i < 4; i++) begin
      v_cand = LSB_HIGH ? (v_base + 2'(i)) : (v_base - 2'(i));
      if (!v_found && w_tvalid[v_cand]) begin
        v_found = 1'b1;
        w_win   = v_cand;
      end
    end
  end

  // Handshake: a beat moves on an edge only when valid and ready are both high at that edge;
  // the egress register accepts a new beat whenever it is empty or being drained.
  assign w_active     = (r_state == S_ACTIVE);
  assign w_out_free   = !r_out_tvalid || output_tready;
  assign w_sel_tvalid = w_tvalid[r_grant_idx];
  assign w_accept     = w_active && w_sel_tvalid && w_out_free && !w_wdog_fire;
  assign w_synth_load = w_wdog_fire && w_out_free;
  assign w_frame_end  = (w_accept && w_tlast[r_grant_idx]) || w_synth_load;
  assign w_ready      = (w_active && w_out_free && !w_wdog_fire) ? (4'b0001 << r_grant_idx) : 4'b0000;

`ifdef AXIS_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog_cnt;

  assign w_wdog_fire = w_active && (r_wdog_cnt == WDOG_W'(WDOG_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog_cnt <= '0;
    end else if (!w_active || w_accept || w_synth_load) begin
      r_wdog_cnt <= '0;
    end else if (!w_sel_tvalid && !w_wdog_fire) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end
`else
  assign w_wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (|w_tvalid) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_frame_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_idx  <= 2'd0;
      r_ptr        <= 2'd0;
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tlast  <= 1'b0;
      r_out_tuser  <= '0;
    end else begin
      if (!w_active && (|w_tvalid)) begin
        r_grant_idx <= w_win;
      end
      if (w_frame_end) begin
        r_ptr <= LSB_HIGH ? (r_grant_idx + 2'd1) : (r_grant_idx - 2'd1);
      end
      if (w_accept) begin
        r_out_tvalid <= 1'b1;
        r_out_tdata  <= w_tdata[r_grant_idx];
        r_out_tlast  <= w_tlast[r_grant_idx];
        r_out_tuser  <= w_tuser[r_grant_idx];
      end else if (w_synth_load) begin
        // Synthetic terminator closes a stalled frame and flags it via tuser.
        r_out_tvalid <= 1'b1;
        r_out_tdata  <= '0;
        r_out_tlast  <= 1'b1;
        r_out_tuser  <= '1;
      end else if (output_tready) begin
        r_out_tvalid <= 1'b0;
      end
    end
  end

  assign input_0_tready = w_ready[0];
  assign input_1_tready = w_ready[1];
  assign input_2_tready = w_ready[2];
  assign input_3_tready = w_ready[3];
  assign output_tvalid  = r_out_tvalid;
  assign output_tdata   = r_out_tdata;
  assign output_tlast   = r_out_tlast;
  assign output_tuser   = r_out_tuser;
  assign grant_valid    = w_active;
  assign grant_idx      = r_grant_idx;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_axis_frame_arbiter_ctrl.sv
// Directed bench for axis_frame_arbiter_ctrl: three instances cover PRIORITY/HIGH,
// ROUND_ROBIN/HIGH and PRIORITY/LOW; the watchdog case builds with AXIS_ARB_WDOG_EN.
module tb_axis_frame_arbiter_ctrl;

  logic             clk;
  logic             rst;
  logic [7:0]       in_tdata  [3][4];
  logic [0:0]       in_tuser  [3][4];
  logic [3:0]       in_tvalid [3];
  logic [3:0]       in_tlast  [3];
  logic             o_tready  [3];
  wire  [3:0]       w_tready  [3];
  wire  [7:0]       o_tdata   [3];
  wire              o_tvalid  [3];
  wire              o_tlast   [3];
  wire  [0:0]       o_tuser   [3];
  wire              gv        [3];
  wire  [1:0]       gidx      [3];
  wire              dbg_state [3];

  int n_tests;
  int n_fail;

  // Beat encoding in all queues: {tlast, tuser, tdata}
  logic [9:0] src_q [4][$];
  logic [9:0] cap_q [$];
  logic [9:0] exp_q [$];
  logic [1:0] grant_q [$];
  logic [9:0] snap_d [$];
  logic [3:0] snap_rdy [$];
  logic       snap_ov [$];
  logic       snap_gv [$];
  int         first_valid;
  int         hold_lo;
  int         hold_hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam string ARB = (g == 1) ? "ROUND_ROBIN" : "PRIORITY";
    localparam string LSB = (g == 2) ? "LOW" : "HIGH";
    axis_frame_arbiter_ctrl #(
      .DATA_WIDTH(8), .USER_WIDTH(1), .ARB_TYPE(ARB), .LSB_PRIORITY(LSB), .WDOG_CYCLES(4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .input_0_tdata(in_tdata[g][0]), .input_0_tvalid(in_tvalid[g][0]), .input_0_tlast(in_tlast[g][0]),
      .input_0_tuser(in_tuser[g][0]), .input_0_tready(w_tready[g][0]),
      .input_1_tdata(in_tdata[g][1]), .input_1_tvalid(in_tvalid[g][1]), .input_1_tlast(in_tlast[g][1]),
      .input_1_tuser(in_tuser[g][1]), .input_1_tready(w_tready[g][1]),
      .input_2_tdata(in_tdata[g][2]), .input_2_tvalid(in_tvalid[g][2]), .input_2_tlast(in_tlast[g][2]),
      .input_2_tuser(in_tuser[g][2]), .input_2_tready(w_tready[g][2]),
      .input_3_tdata(in_tdata[g][3]), .input_3_tvalid(in_tvalid[g][3]), .input_3_tlast(in_tlast[g][3]),
      .input_3_tuser(in_tuser[g][3]), .input_3_tready(w_tready[g][3]),
      .output_tdata(o_tdata[g]), .output_tvalid(o_tvalid[g]), .output_tlast(o_tlast[g]),
      .output_tuser(o_tuser[g]), .output_tready(o_tready[g]),
      .grant_valid(gv[g]), .grant_idx(gidx[g]), .o_dbg_state(dbg_state[g])
    );
  end

  task automatic clear_logs();
    cap_q.delete();
    exp_q.delete();
    grant_q.delete();
    snap_d.delete();
    snap_rdy.delete();
    snap_ov.delete();
    snap_gv.delete();
    for (int k = 0; k < 4; k++) src_q[k].delete();
    first_valid = -1;
    hold_lo = 0;
    hold_hi = 0;
  endtask

  // Drives instance g from src_q for a fixed number of cycles, logging the egress side.
  task automatic run(input int g, input int cycles);
    logic [3:0] acc;
    logic       gv_prev;
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (src_q[k].size() > 0) begin
          in_tvalid[g][k] = 1'b1;
          in_tdata[g][k]  = src_q[k][0][7:0];
          in_tuser[g][k]  = src_q[k][0][8];
          in_tlast[g][k]  = src_q[k][0][9];
        end else begin
          in_tvalid[g][k] = 1'b0;
        end
      end
      o_tready[g] = !(c >= hold_lo && c < hold_hi);
      @(negedge clk);
      acc     = in_tvalid[g] & w_tready[g];
      gv_prev = gv[g];
      snap_d.push_back({o_tlast[g], o_tuser[g], o_tdata[g]});
      snap_rdy.push_back(w_tready[g]);
      snap_ov.push_back(o_tvalid[g]);
      snap_gv.push_back(gv[g]);
      if (o_tvalid[g]) begin
        if (first_valid < 0) first_valid = c;
        if (o_tready[g]) cap_q.push_back({o_tlast[g], o_tuser[g], o_tdata[g]});
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (acc[k]) void'(src_q[k].pop_front());
      if (gv[g] && !gv_prev) grant_q.push_back(gidx[g]);
    end
    in_tvalid[g] = 4'b0000;
    o_tready[g]  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      o_tready[g]  = 1'b1;
      in_tvalid[g] = 4'b1111;
      in_tlast[g]  = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        in_tdata[g][k] = 8'h5A;
        in_tuser[g][k] = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if ({o_tvalid[g], o_tlast[g], o_tuser[g], o_tdata[g]} !== 11'h000) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got v=%b l=%b u=%b d=%h, expected all 0", g, o_tvalid[g], o_tlast[g], o_tuser[g], o_tdata[g]);
      end
      n_tests++;
      if ({gv[g], gidx[g], w_tready[g]} !== 7'h00) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got gv=%b gidx=%0d tready=%b, expected 0/0/0000", g, gv[g], gidx[g], w_tready[g]);
      end
    end
    for (int g = 0; g < 3; g++) in_tvalid[g] = 4'b0000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (gv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_request: got grant_valid=%b, expected 0", gv[0]);
    end
  endtask

  task automatic test_priority_high();
    clear_logs();
    src_q[1] = '{10'h0A0, 10'h0A1, 10'h2A2};
    src_q[2] = '{10'h0B0, 10'h1B1, 10'h2B2};
    exp_q    = '{10'h0A0, 10'h0A1, 10'h2A2, 10'h0B0, 10'h1B1, 10'h2B2};
    run(0, 14);
    n_tests++;
    if (first_valid !== 2) begin
      n_fail++;
      $display("FAIL pri_first_latency: got cycle %0d, expected 2", first_valid);
    end
    n_tests++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL pri_beat_count: got %0d, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pri_beat[%0d]: got %h, expected %h", i, cap_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (grant_q.size() != 2 || grant_q[0] !== 2'd1 || grant_q[1] !== 2'd2) begin
      n_fail++;
      $display("FAIL pri_grants: got %p, expected 1,2", grant_q);
    end
  endtask

  task automatic test_round_robin();
    clear_logs();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 4; k++)
        src_q[k].push_back({2'b10, 4'(k), 4'(b)});
    for (int i = 0; i < 12; i++) exp_q.push_back({2'b10, 4'(i % 4), 4'(i / 4)});
    run(1, 30);
    n_tests++;
    if (grant_q.size() != 12) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d, expected 12", grant_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (grant_q[i] !== 2'(i % 4)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %0d, expected %0d", i, grant_q[i], i % 4);
      end
    end
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rr_beat[%0d]: got %h, expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    src_q[0] = '{10'h0C0, 10'h0C1, 10'h0C2, 10'h2C3};
    exp_q    = '{10'h0C0, 10'h0C1, 10'h0C2, 10'h2C3};
    hold_lo  = 3;
    hold_hi  = 8;
    run(0, 14);
    n_tests++;
    if (snap_rdy[2][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_before: got %b, expected 1", snap_rdy[2][0]);
    end
    for (int c = 3; c < 8; c++) begin
      n_tests++;
      if (snap_ov[c] !== 1'b1 || snap_d[c] !== 10'h0C1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b beat=%h, expected v=1 beat=0c1", c, snap_ov[c], snap_d[c]);
      end
      n_tests++;
      if (snap_rdy[c][0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_tready[%0d]: got %b, expected 0", c, snap_rdy[c][0]);
      end
    end
    n_tests++;
    if (cap_q.size() != 4) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d, expected 4", cap_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat[%0d]: got %h, expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    src_q[1] = '{10'h211};
    run(1, 6);
    clear_logs();
    src_q[2] = '{10'h020, 10'h021, 10'h022, 10'h223};
    run(1, 3);
    n_tests++;
    if (gv[1] !== 1'b1 || gidx[1] !== 2'd2 || o_tdata[1] !== 8'h21) begin
      n_fail++;
      $display("FAIL mid_prereset: got gv=%b gidx=%0d d=%h, expected 1/2/21", gv[1], gidx[1], o_tdata[1]);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({o_tvalid[1], o_tlast[1], o_tuser[1], o_tdata[1]} !== 11'h000) begin
      n_fail++;
      $display("FAIL mid_reset_out: got v=%b l=%b u=%b d=%h, expected all 0", o_tvalid[1], o_tlast[1], o_tuser[1], o_tdata[1]);
    end
    n_tests++;
    if (gv[1] !== 1'b0 || gidx[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_grant: got gv=%b gidx=%0d, expected 0/0", gv[1], gidx[1]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_logs();
    src_q[0] = '{10'h230};
    src_q[3] = '{10'h233};
    run(1, 10);
    n_tests++;
    if (grant_q.size() != 2 || grant_q[0] !== 2'd0 || grant_q[1] !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_after_reset_grants: got %p, expected 0,3", grant_q);
    end
    n_tests++;
    if (cap_q.size() != 2 || cap_q[0] !== 10'h230 || cap_q[1] !== 10'h233) begin
      n_fail++;
      $display("FAIL mid_after_reset_beats: got %p, expected 230,233", cap_q);
    end
  endtask

  task automatic test_priority_low();
    clear_logs();
    src_q[0] = '{10'h0E0, 10'h2E1};
    src_q[3] = '{10'h0F0, 10'h2F1};
    exp_q    = '{10'h0F0, 10'h2F1, 10'h0E0, 10'h2E1};
    run(2, 14);
    n_tests++;
    if (grant_q.size() != 2 || grant_q[0] !== 2'd3 || grant_q[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL low_grants: got %p, expected 3,0", grant_q);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL low_beat[%0d]: got %h, expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef AXIS_ARB_WDOG_EN
  task automatic test_watchdog();
    int syn_c;
    clear_logs();
    src_q[0] = '{10'h040};
    src_q[1] = '{10'h241};
    exp_q    = '{10'h040, 10'h300, 10'h241};
    run(0, 16);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wdog_beat[%0d]: got %h, expected %h", i, cap_q[i], exp_q[i]);
      end
    end
    syn_c = -1;
    for (int c = 0; c < snap_d.size(); c++)
      if (syn_c < 0 && snap_ov[c] && snap_d[c] == 10'h300) syn_c = c;
    n_tests++;
    if (syn_c < 0 || snap_gv[syn_c] !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_grant_drop: synthetic at cycle %0d, expected grant_valid 0 there", syn_c);
    end
    n_tests++;
    if (grant_q.size() != 2 || grant_q[1] !== 2'd1) begin
      n_fail++;
      $display("FAIL wdog_next_grant: got %p, expected 0,1", grant_q);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_logs();
    test_reset();
    test_priority_high();
    test_round_robin();
    test_backpressure();
    test_reset_midframe();
    test_priority_low();
`ifdef AXIS_ARB_WDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
